// File: rtl/mudi_unit_if.sv
// Bus between the E-stage decoder/stall logic and the multiply/divide sequencer.
// Master drives the request side; slave (mudi_unit) returns Start/Busy/HLOut.
interface mudi_unit_if;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic        HLOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] HLOut;

  modport master (
    output MDStart, MDOp, HLOp, A, B, Req,
    input  Start, Busy, HLOut
  );

  modport slave (
    input  MDStart, MDOp, HLOp, A, B, Req,
    output Start, Busy, HLOut
  );
endinterface

// File: rtl/mudi_unit.sv
// Multiply/divide sequencer owning HI/LO. The 64-bit result is computed in the
// launch cycle and parked in pend_*; a down-counter models the multi-cycle
// latency and commits the parked result to HI/LO when it expires.
module mudi_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mudi_unit_if.slave bus
);

  localparam logic [2:0] MUDI_OTH   = 3'd0;
  localparam logic [2:0] MUDI_MULT  = 3'd1;
  localparam logic [2:0] MUDI_MULTU = 3'd2;
  localparam logic [2:0] MUDI_DIV   = 3'd3;
  localparam logic [2:0] MUDI_DIVU  = 3'd4;
  localparam logic [2:0] MUDI_MTHI  = 3'd5;
  localparam logic [2:0] MUDI_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;
  // Cleared for divide-by-zero so completion leaves HI/LO untouched.
  logic        pend_wr_reg, pend_wr_next;

  logic        busy;
  logic        start;
  logic        is_md_op;
  logic        is_mult;
  logic        launch;
  logic        div_zero;
  logic [31:0] res_hi, res_lo;

  assign busy      = (state_reg == BUSY);
  assign start     = bus.MDStart & ~bus.Req & ~busy;
  assign is_md_op  = (bus.MDOp == MUDI_MULT) || (bus.MDOp == MUDI_MULTU) ||
                     (bus.MDOp == MUDI_DIV)  || (bus.MDOp == MUDI_DIVU);
  assign is_mult   = (bus.MDOp == MUDI_MULT) || (bus.MDOp == MUDI_MULTU);
  assign launch    = start & is_md_op;
  assign div_zero  = (bus.B == 32'd0);

  assign bus.Start = start;
  assign bus.Busy  = busy;
  assign bus.HLOut = bus.HLOp ? hi_reg : lo_reg;

  // Arithmetic datapath: result of the op presented this cycle.
  always_comb begin
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s;
    a_s    = $signed(bus.A);
    b_s    = $signed(bus.B);
    prod_s = a_s * b_s;
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (bus.MDOp)
      MUDI_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MUDI_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MUDI_DIV: begin
        if (div_zero) begin
          res_hi = 32'd0;
          res_lo = 32'd0;
        end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
          // Two's-complement overflow case: quotient wraps to the dividend.
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_lo = $unsigned(a_s / b_s);
          res_hi = $unsigned(a_s % b_s);
        end
      end
      MUDI_DIVU: begin
        if (!div_zero) begin
          res_lo = bus.A / bus.B;
          res_hi = bus.A % bus.B;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // State register: everything clears on reset, discarding any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
    end
  end

  // Next-state: launch/mthi/mtlo in IDLE; count down and commit in BUSY.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next   = BUSY;
          cnt_next     = is_mult ? MULT_N : DIV_N;
          pend_hi_next = res_hi;
          pend_lo_next = res_lo;
          pend_wr_next = is_mult | ~div_zero;
        end else if (!bus.Req && bus.MDOp == MUDI_MTHI) begin
          hi_next = bus.A;
        end else if (!bus.Req && bus.MDOp == MUDI_MTLO) begin
          lo_next = bus.A;
        end
      end
      BUSY: begin
        // Req is deliberately ignored here: the issuing instruction has committed.
        if (cnt_reg <= 4'd1) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mudi_unit.sv
// Self-checking bench for mudi_unit: table of mult/div vectors plus hand
// sequences for busy-time ignores, Req cancellation, div-by-zero and reset.
module tb_mudi_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  res_t sb[$];

  mudi_unit_if bus();

  mudi_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bus.HLOp = 1'b1;
    #1 chk({name, "_hi"}, bus.HLOut, hi);
    bus.HLOp = 1'b0;
    #1 chk({name, "_lo"}, bus.HLOut, lo);
  endtask

  // mid_kind: 0 none, 1 issue a DIV during busy cycle mid_cyc, 2 pulse Req then.
  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int mid_cyc, input int mid_kind);
    int   n;
    int   exp_n;
    res_t r;
    exp_n = (op <= 3'd2) ? MULT_N : DIV_N;
    @(negedge clk);
    bus.MDStart = 1'b1;
    bus.MDOp    = op;
    bus.A       = a;
    bus.B       = b;
    #1 chk({name, "_start"}, 32'(bus.Start), 32'd1);
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    @(posedge clk); #1;
    bus.MDStart = 1'b0;
    bus.MDOp    = 3'd0;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      if (n == mid_cyc && mid_kind == 1) begin
        bus.MDStart = 1'b1;
        bus.MDOp    = 3'd3;
        bus.A       = 32'd100;
        bus.B       = 32'd3;
        #1 chk({name, "_start_ign"}, 32'(bus.Start), 32'd0);
      end else if (n == mid_cyc && mid_kind == 2) begin
        bus.Req = 1'b1;
      end
      @(posedge clk); #1;
      bus.MDStart = 1'b0;
      bus.MDOp    = 3'd0;
      bus.Req     = 1'b0;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      r = sb.pop_front();
      chk_hilo(name, r.hi, r.lo);
    end
    $display("txn %s op=%0d a=0x%08h b=0x%08h busy=%0d", name, op, a, b, n);
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [31:0] a, input logic req);
    @(negedge clk);
    bus.MDOp = op;
    bus.A    = a;
    bus.Req  = req;
    @(posedge clk); #1;
    bus.MDOp = 3'd0;
    bus.Req  = 1'b0;
    chk("mt_busy", 32'(bus.Busy), 32'd0);
    $display("txn mt op=%0d a=0x%08h req=%0d", op, a, req);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC};
    vecs[3] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{3'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8] = '{3'd1, 32'h1234_5678, 32'd0,        32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    reset       = 1'b1;
    bus.MDStart = 1'b0;
    bus.MDOp    = 3'd0;
    bus.HLOp    = 1'b0;
    bus.A       = 32'd0;
    bus.B       = 32'd0;
    bus.Req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_start", 32'(bus.Start), 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);

    // MULTU with an ignored DIV issued in busy cycle 2.
    run_md("multu_ign", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 2, 1);

    for (int i = 0; i < 10; i++) begin
      run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 0, 0);
    end

    // Preload, then divide by zero leaves HI/LO intact.
    mt_write(3'd5, 32'h0000_1234, 1'b0);
    mt_write(3'd6, 32'h0000_5678, 1'b0);
    chk_hilo("mt", 32'h0000_1234, 32'h0000_5678);
    run_md("div0", 3'd3, 32'd55, 32'd0, 32'h0000_1234, 32'h0000_5678, 0, 0);
    run_md("divu0", 3'd4, 32'd55, 32'd0, 32'h0000_1234, 32'h0000_5678, 0, 0);

    // Req blocks MTHI and a MULT launch.
    mt_write(3'd5, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    bus.MDStart = 1'b1;
    bus.MDOp    = 3'd1;
    bus.A       = 32'd3;
    bus.B       = 32'd4;
    bus.Req     = 1'b1;
    #1 chk("req_start", 32'(bus.Start), 32'd0);
    @(posedge clk); #1;
    bus.MDStart = 1'b0;
    bus.MDOp    = 3'd0;
    bus.Req     = 1'b0;
    chk("req_busy", 32'(bus.Busy), 32'd0);
    chk_hilo("req", 32'h0000_1234, 32'h0000_5678);
    $display("txn req_mult a=3 b=4 blocked");

    // Req pulse in busy cycle 2 does not cancel.
    run_md("mult_req", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 2, 2);

    // Reset in busy cycle 4 of a DIV discards the pending result.
    mt_write(3'd5, 32'h0000_AAAA, 1'b0);
    @(negedge clk);
    bus.MDStart = 1'b1;
    bus.MDOp    = 3'd3;
    bus.A       = 32'd50;
    bus.B       = 32'd7;
    @(posedge clk); #1;
    bus.MDStart = 1'b0;
    bus.MDOp    = 3'd0;
    chk("rstmid_busy1", 32'(bus.Busy), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", 32'(bus.Busy), 32'd0);
    chk_hilo("rstmid", 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("rstmid_late_busy", 32'(bus.Busy), 32'd0);
    end
    chk_hilo("rstmid_late", 32'd0, 32'd0);
    $display("txn div_reset_mid a=50 b=7 discarded");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mudi_unit.md
Name: mudi_unit

Overview:
- Multiply/divide sequencer for the P7 pipeline, located in the E stage beside the ALU.
- Accepts the decoder's MDStart/MDOp, runs multi-cycle mult/div operations and owns the HI/LO registers.
- Exposes Start/Busy so the stall unit can hold later HI/LO users.
- Services mthi/mtlo writes and mfhi/mflo reads (HLOp) and honours exception/interrupt cancellation (Req).

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, Busy cycles for div/divu (1..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- MDStart  input  1  E-stage instruction is mult/multu/div/divu
- MDOp  input  3  op code: 0 OTH, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO (header MUDI_* values)
- HLOp  input  1  read select: 1 = HI, 0 = LO
- A  input  32  forwarded rs value (multiplicand/dividend, mthi/mtlo data)
- B  input  32  forwarded rt value (multiplier/divisor)
- Req  input  1  exception/interrupt flush this cycle; E-stage instruction must not take effect
- Start  output  1  combinational = MDStart & !Req & !Busy
- Busy  output  1  registered; operation in flight
- HLOut  output  32  combinational HLOp ? HI : LO

Behaviour:
- Reset state: HI=0, LO=0, cnt=0, Busy=0, pending result regs=0. Start and HLOut follow their equations, so HLOut=0 after reset.
- State machine:
  - IDLE (cnt==0) and BUSY (cnt!=0); Busy = (cnt!=0), driven from a register, never from inputs.
  - IDLE -> BUSY on an edge where Start=1 and MDOp in {1..4}.
  - On that edge, latch the computed 64-bit result into pendHI/pendLO and load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - BUSY: decrement cnt each edge. On the edge where cnt==1, HI<=pendHI, LO<=pendLO, cnt<=0.
- Latency: Busy is high for exactly N cycles following the Start cycle. The new HI/LO are visible in the first cycle with Busy=0.
- Arithmetic:
  - MULT: {HI,LO} = signed(A)*signed(B).
  - MULTU: unsigned product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor==0 (DIV/DIVU): still runs DIV_CYCLES with Busy, and HI/LO are left unchanged on completion.
- MTHI/MTLO: when MDOp=5/6, Req=0 and Busy=0, HI<=A (or LO<=A) on that edge, with no Busy.
- Ignored requests:
  - MTHI/MTLO while Busy are ignored; the stall unit guarantees this never happens in a legal pipeline.
  - MDStart while Busy is ignored: Start=0, and neither cnt nor pend is altered.
- Req=1: suppresses Start, MTHI and MTLO in the same cycle. An operation already BUSY is not cancelled; it completes and writes HI/LO, because the issuing instruction has already committed past E.
- Reset mid-operation: cnt=0, Busy=0, HI=LO=0 next cycle, and the pending result is discarded.
- HLOut during Busy returns the old HI/LO; the stall unit prevents mfhi/mflo from consuming it.
- MDOp=0 or MDStart=0 with MDOp in 1..4: no state change. Start requires MDStart=1.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5, Req=0 -> Start=1 for one cycle, then Busy=1 for 5 cycles. Next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE. A DIV issued during Busy is ignored (cnt unaffected, Busy ends on time).
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same inputs -> LO=0x7FFFFFFC, HI=1.
- Preload via MTHI 0x1234, MTLO 0x5678, then DIV with B=0 -> Busy for 10 cycles, HI=0x1234, LO=0x5678 unchanged. HLOp toggles HLOut between the two values.
- MDStart=1 with Req=1 (MULT 3*4) -> Start=0, Busy stays 0, HI/LO unchanged. MULT starts, then Req pulses in cycle 2 of Busy -> completes and HI/LO = 0/12.
- DIV starts, then reset is asserted in Busy cycle 4 -> next cycle Busy=0, HI=LO=0. No late write appears in the following 10 cycles.
